latch_dff_pair: RTL and testbench
=================================

Name: latch_dff_pair

Overview:
- Pair of parameterised storage elements sharing one reset: a level-sensitive transparent latch and a rising-edge D flip-flop.
- Generic leaf primitive for the practice/storage library. Used wherever both a latched copy and a registered copy of a bus are needed, e.g. comparing latch and flop timing on the same data.
- Only the flop is clocked. The latch is gated by its own enable.

Parameters:
- WIDTH, 1, bit width of both data paths and both outputs.
- RST_VAL, {WIDTH{1'b0}}, value loaded into both storage elements while rst is high.

Ports:
- clk  input  1  clock; the flop samples on the rising edge; the latch ignores it.
- rst  input  1  asynchronous, active-high reset; clears both the latch and the flop.
- data  input  WIDTH  latch data input.
- enable  input  1  latch gate; high = transparent, low = hold.
- d  input  WIDTH  flop data input.
- q_latch  output  WIDTH  latch output.
- q_dff  output  WIDTH  flop output.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: q_latch = RST_VAL and q_dff = RST_VAL immediately on rst rising, with no clock needed. Both hold RST_VAL for as long as rst is high.
- Latch:
  - rst high: q_latch = RST_VAL. Reset wins over enable.
  - rst low, enable high: q_latch follows data combinationally, zero cycles.
  - rst low, enable low: q_latch holds the value present when enable fell.
  - On rst release with enable high, q_latch immediately follows data again.
  - On rst release with enable low, q_latch holds RST_VAL until enable next goes high.
  - The latch output does not depend on clk.
- Flop:
  - On the rising edge of clk with rst low, q_dff <= d. Latency is 1 clock edge.
  - Between edges q_dff holds its value regardless of changes on d.
  - rst deassertion coincident with a clk rising edge: that edge does not load. The first load is on the next rising edge with rst low.
  - If rst pulses high between edges, q_dff becomes RST_VAL at once and stays there until the next qualifying edge.
- Data and enable changing in the same delta as a clk edge: the latch output reflects the new values. The flop samples d as it was before the edge (nonblocking semantics).
- No X generation: every output is defined from reset onward.
- Widths: no arithmetic; all paths are exactly WIDTH bits, with no extension or truncation.

Optional Feature:
- Macro LATCH_DFF_PAIR_CE_EN.
- When defined:
  - Adds input ce (1 bit).
  - On a rising clk edge with rst low, q_dff loads d only if ce = 1; otherwise it holds.
  - Reset still overrides ce asynchronously.
  - The latch is unaffected by ce.
- When undefined:
  - No ce port exists.
  - The flop loads on every rising edge.

Test Plan:
- Reset: WIDTH=1, RST_VAL=0. Drive rst=1 mid-cycle with clk low, d=1, data=1, enable=1 -> q_dff=0 and q_latch=0 immediately, with no clk edge needed.
- Latch transparency/hold: rst=0, enable=1, data 0->1 -> q_latch=1 in the same timestep. Then enable=0, data=0 -> q_latch stays 1.
- Flop capture: clk period 2 units. d=1 set at t=4 between edges -> q_dff stays at old value until the next rising edge, then becomes 1. d->0 with no edge -> q_dff stays 1.
- Async reset mid-operation: q_dff=1, q_latch=1, enable=1. rst=1 at t=6 for 2 units -> both outputs 0 throughout the pulse. After release, q_latch=data immediately and q_dff=d after the next rising edge.
- Reset release on an edge: rst falls at the same time as clk rises, d=1 -> q_dff stays 0 on that edge and is 1 after the following rising edge.
- Feature LATCH_DFF_PAIR_CE_EN, WIDTH=8: d=8'hA5 with ce=0 across 2 edges -> q_dff stays 8'h00. ce=1 -> q_dff=8'hA5 after 1 edge.

Source files
------------

// File: rtl/latch_dff_pair.sv
// latch_dff_pair: a transparent latch and a rising-edge D flop sharing one async active-high reset.
// Latency: the latch passes data through in zero cycles while enabled; the flop updates one clk edge after sampling d.
// Backpressure: none. Both elements always accept new data. Optional flop clock enable via macro LATCH_DFF_PAIR_CE_EN.

module latch_dff_pair #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
`ifdef LATCH_DFF_PAIR_CE_EN
  input  logic             ce,
`endif
  output logic [WIDTH-1:0] q_latch,
  output logic [WIDTH-1:0] q_dff
);

  // Flop load qualifier: the clock enable when the feature is built in, otherwise every edge loads.
  logic load;
`ifdef LATCH_DFF_PAIR_CE_EN
  assign load = ce;
`else
  assign load = 1'b1;
`endif

  // Level-sensitive storage: reset dominates the gate; when the gate is closed the last value is held.
  always_latch begin
    if (rst) begin
      q_latch <= RST_VAL;
    end else if (enable) begin
      q_latch <= data;
    end
  end

  // Edge-triggered storage: reset applies immediately without a clock; an edge seen while rst is
  // still high (including a release coincident with that edge) takes the reset branch, not d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_dff <= RST_VAL;
    end else if (load) begin
      q_dff <= d;
    end
  end

endmodule

// File: tb/tb_latch_dff_pair.sv
// Bench for latch_dff_pair: directed vectors, expected values pushed into a scoreboard queue
// and consumed by a separate monitor process one time unit after each request.
// Clock period 10 units: rising edges at 5, 15, 25, ...; falling edges at 10, 20, ...

module tb_latch_dff_pair;

  localparam int unsigned      W    = 8;
  localparam logic [W-1:0]     RVAL = 8'h3C;

  logic         clk;
  logic         rst;
  logic [W-1:0] data;
  logic         enable;
  logic [W-1:0] d;
`ifdef LATCH_DFF_PAIR_CE_EN
  logic         ce;
`endif
  logic [W-1:0] q_latch;
  logic [W-1:0] q_dff;

  latch_dff_pair #(
    .WIDTH   (W),
    .RST_VAL (RVAL)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .enable  (enable),
    .d       (d),
`ifdef LATCH_DFF_PAIR_CE_EN
    .ce      (ce),
`endif
    .q_latch (q_latch),
    .q_dff   (q_dff)
  );

  typedef struct {
    string        name;
    logic [W-1:0] exp_latch;
    logic [W-1:0] exp_dff;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push one expectation and give the monitor time to sample it before inputs move again.
  task automatic expect_now(input string name, input logic [W-1:0] el, input logic [W-1:0] ed);
    exp_t e;
    e.name      = name;
    e.exp_latch = el;
    e.exp_dff   = ed;
    exp_q.push_back(e);
    -> chk_ev;
    #2;
  endtask

  // Monitor: one unit after a request, pop every pending expectation and compare both outputs.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (q_latch === e.exp_latch) n_pass++;
        else $display("FAIL %s q_latch: got %h want %h (t=%0t)", e.name, q_latch, e.exp_latch, $time);
        n_checks++;
        if (q_dff === e.exp_dff) n_pass++;
        else $display("FAIL %s q_dff: got %h want %h (t=%0t)", e.name, q_dff, e.exp_dff, $time);
      end
    end
  end

  initial begin
    rst    = 1'b0;
    data   = 8'h00;
    enable = 1'b0;
    d      = 8'h00;
`ifdef LATCH_DFF_PAIR_CE_EN
    ce     = 1'b1;
`endif
    #2;
    // t=2, clk low: reset with every input pushing the other way, no edge needed.
    rst = 1'b1; d = 8'hFF; data = 8'hFF; enable = 1'b1;
    expect_now("reset_async", RVAL, RVAL);
    @(posedge clk); #1;                                   // t=6, edge at 5 held in reset
    expect_now("reset_hold_edge", RVAL, RVAL);
    @(negedge clk);                                       // t=10
    rst = 1'b0;                                           // enable high: latch follows data at once
    expect_now("release_latch_follows", 8'hFF, RVAL);
    data = 8'h5A;                                         // t=12
    expect_now("latch_transparent", 8'h5A, RVAL);
    @(posedge clk); #1;                                   // t=16, edge at 15 loaded d=FF
    enable = 1'b0; data = 8'h00;
    expect_now("latch_hold_flop_load", 8'h5A, 8'hFF);
    d = 8'h0F;                                            // t=18, between edges
    expect_now("flop_hold_between", 8'h5A, 8'hFF);
    @(posedge clk); #1;                                   // t=26, edge at 25 loaded 0F
    d = 8'h00;
    expect_now("flop_load_second", 8'h5A, 8'h0F);
    @(negedge clk);                                       // t=30
    enable = 1'b1; data = 8'hA5;
    expect_now("latch_reopen", 8'hA5, 8'h0F);
    rst = 1'b1;                                           // t=32, async reset mid-operation
    expect_now("async_mid", RVAL, RVAL);
    @(posedge clk); #1;                                   // t=36, reset still high across edge 35
    data = 8'hC3;
    expect_now("reset_beats_enable", RVAL, RVAL);
    rst = 1'b0; d = 8'h77;                                // t=38, release between edges
    expect_now("release_mid", 8'hC3, RVAL);
    @(posedge clk); #1;                                   // t=46
    expect_now("first_load_after_release", 8'hC3, 8'h77);
    rst = 1'b1;                                           // t=48, short pulse between edges
    expect_now("pulse_between_edges", RVAL, RVAL);
    rst = 1'b0; d = 8'hE7;                                // t=50
    expect_now("pulse_release", 8'hC3, RVAL);
    @(posedge clk); #1;                                   // t=56
    expect_now("load_after_pulse", 8'hC3, 8'hE7);
    rst = 1'b1; d = 8'h11; enable = 1'b0;                 // t=58
    expect_now("reset_gate_closed", RVAL, RVAL);
    // Release in the same delta as the rising edge at 65: the flop must still see rst high.
    @(posedge clk);
    rst <= 1'b0;
    #1;                                                   // t=66
    expect_now("release_on_edge", RVAL, RVAL);
    @(posedge clk); #1;                                   // t=76
    expect_now("load_after_edge_release", RVAL, 8'h11);
    enable = 1'b1;                                        // t=78, data still C3
    expect_now("latch_opens_after_hold", 8'hC3, 8'h11);
`ifdef LATCH_DFF_PAIR_CE_EN
    ce = 1'b0; d = 8'hA5;                                 // t=80
    repeat (2) @(posedge clk);
    #1;                                                   // t=96
    expect_now("ce_low_holds", 8'hC3, 8'h11);
    ce = 1'b1;
    @(posedge clk); #1;                                   // t=106
    expect_now("ce_high_loads", 8'hC3, 8'hA5);
    ce = 1'b0; rst = 1'b1;                                // t=108
    expect_now("reset_overrides_ce", RVAL, RVAL);
    rst = 1'b0;
`endif
    // Bounded drain of the scoreboard; leftovers count as a failed comparison.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
